// File: rtl/matrix_mem_pkg.sv
// Shared definitions for the result-memory region and its readback engine.
package matrix_mem_pkg;
  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned RES_DATA_W = 16;
  localparam int unsigned LANES      = 8;
  localparam int unsigned RES_GROUPS = 512;

  localparam logic [ADDR_W-1:0] RES_BASE_ADDR = 14'h2000;
  localparam logic [ADDR_W-1:0] RES_LAST_ADDR = 14'h2FFF;

  typedef logic [LANES*RES_DATA_W-1:0] res_group_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rb_state_e;
endpackage

// File: rtl/result_readback_128x128_if.sv
// Memory read port plus output stream of the result readback engine.
interface result_readback_128x128_if
  import matrix_mem_pkg::*;
#(
  parameter int unsigned DATA_W = RES_DATA_W
) ();
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [LANES*DATA_W-1:0]   rd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic                      out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_data, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/rb_group_fifo.sv
// Show-ahead FIFO for read-back groups; head reads as zero while empty.
module rb_group_fifo #(
  parameter  int unsigned W     = 129,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/result_readback_128x128.sv
// Streams the 512-group result region out of the 8-bank memory under
// credit control so the output FIFO can never overflow.
module result_readback_128x128
  import matrix_mem_pkg::*;
#(
  parameter int unsigned       DATA_W     = RES_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = RES_BASE_ADDR,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = RES_LAST_ADDR,
  parameter int unsigned       RD_LAT     = 2,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  result_readback_128x128_if.master bus
);
  localparam int unsigned GW       = LANES * DATA_W;
  localparam int unsigned EW       = GW + 1;
  localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW       = CW + 1;
  localparam int unsigned IW       = 10;
  localparam int unsigned LS       = $clog2(LANES);
  localparam int unsigned GIW      = $clog2(RES_GROUPS);
  localparam int unsigned LAST_IDX = (32'(LAST_ADDR) - 32'(BASE_ADDR) + 1) / LANES - 1;

  rb_state_e         state_q, state_d;
  logic [IW-1:0]     issue_idx_q;
  logic [IW-1:0]     ret_idx_q;
  logic [CW-1:0]     inflight_q;
  logic [RD_LAT-1:0] vpipe_q;
  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     head;
  logic              issue;
  logic              start_ok;
  logic              credit_ok;
  logic              ret_valid;
  logic              pop;

  // Occupancy uses the registered count: a pop frees credit one cycle later.
  assign credit_ok = (SW'(fifo_count) + SW'(inflight_q)) < SW'(FIFO_DEPTH);
  assign ret_valid = vpipe_q[RD_LAT-1];
  assign pop       = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = READ;
          start_ok = 1'b1;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (issue_idx_q == IW'(LAST_IDX)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && bus.out_last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_idx_q <= '0;
      ret_idx_q   <= '0;
      inflight_q  <= '0;
      vpipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d == READ) || (state_d == DRAIN);
      done       <= (state_d == DONE);
      inflight_q <= inflight_q + CW'(issue) - CW'(ret_valid);
      vpipe_q    <= RD_LAT'({vpipe_q, issue});
      if (start_ok) begin
        issue_idx_q <= '0;
        ret_idx_q   <= '0;
      end else begin
        if (issue)     issue_idx_q <= issue_idx_q + IW'(1);
        if (ret_valid) ret_idx_q   <= ret_idx_q + IW'(1);
      end
    end
  end

  assign bus.rd_en   = issue;
  assign bus.rd_addr = BASE_ADDR + (ADDR_W'(issue_idx_q[GIW-1:0]) << LS);

  rb_group_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_valid),
    .push_data ({ret_idx_q == IW'(LAST_IDX), bus.rd_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = head[GW-1:0];
  assign bus.out_last  = head[GW];
endmodule
